// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU step controller: FSM state encoding and width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

    localparam int STATE_W = 2;

    // The encoding is visible on state_dbg, so the values are fixed.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 2'd0,
        ST_STEP     = 2'd1,
        ST_WAIT_REL = 2'd2,
        ST_RUN      = 2'd3
    } state_e;

endpackage

// File: rtl/input_debouncer.sv
// Synchronizes one asynchronous raw input and debounces it into a stable level plus rising pulse.
// Latency: level follows a clean change SYNC_STAGES+DEBOUNCE_CYCLES clocks later; rise one clock after that.
// Backpressure: none; free-running sampler.
// Ports: clk, rst (sync, active-high), din_raw (async raw input),
//        level (accepted debounced level), rise (one-clock pulse on accepted 0->1).
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din_raw,
    output logic level,
    output logic rise
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DB_W-1:0]        cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   level_prev_q, level_prev_d;
    logic                   rise_q, rise_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], din_raw};
        level_d      = level_q;
        cnt_d        = '0;
        // Count consecutive samples that disagree with the accepted level;
        // any agreeing sample restarts the count, so short glitches never flip it.
        if (synced != level_q) begin
            if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = synced;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Edge detect works off the registered level, adding one clock of latency.
        level_prev_d = level_q;
        rise_d       = level_q & ~level_prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            rise_q       <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            rise_q       <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/cpu_step_controller.sv
// CPU clock-enable generator: single-step pulses per button press, or a periodic train in run mode.
// Latency: clean step press -> cpu_en SYNC_STAGES+DEBOUNCE_CYCLES+2 clocks; first run pulse RUN_DIV clocks after RUN entry.
// Backpressure: none; cpu_en is a free-running one-clock enable with no handshake.
// Ports: clk, rst (sync, active-high), mode_run (raw, 1=run), step (raw button),
//        cpu_en (registered enable), step_count (pulses since reset), state_dbg (FSM state).
module cpu_step_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RUN_DIV         = 4,
    parameter int CNT_W           = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode_run,
    input  logic               step,
    output logic               cpu_en,
    output logic [CNT_W-1:0]   step_count,
    output logic [STATE_W-1:0] state_dbg
);

    localparam int              DIV_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic run_db;
    logic run_rise_unused;
    logic step_db;
    logic step_rise;

    input_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_run_db (
        .clk    (clk),
        .rst    (rst),
        .din_raw(mode_run),
        .level  (run_db),
        .rise   (run_rise_unused)
    );

    input_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk    (clk),
        .rst    (rst),
        .din_raw(step),
        .level  (step_db),
        .rise   (step_rise)
    );

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             cpu_en_q, cpu_en_d;
    logic [CNT_W-1:0] step_count_q, step_count_d;

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        cpu_en_d     = 1'b0;
        step_count_d = step_count_q + CNT_W'(cpu_en_q);
        case (state_q)
            ST_IDLE: begin
                // Run mode takes priority; a coincident step press is dropped.
                if (run_db) begin
                    state_d = ST_RUN;
                    div_d   = '0;
                end else if (step_rise) begin
                    state_d  = ST_STEP;
                    cpu_en_d = 1'b1;
                end
            end
            ST_STEP: begin
                state_d = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                // Button must be released before anything else is considered.
                if (!step_db) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!run_db) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d    = '0;
                    cpu_en_d = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            cpu_en_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            cpu_en_q     <= cpu_en_d;
            step_count_q <= step_count_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign step_count = step_count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
module tb_cpu_step_controller;

    localparam int S = 2;
    localparam int D = 16;
    localparam int W = 16;

    localparam int M_IDLE = 0;
    localparam int M_STEP = 1;
    localparam int M_WAIT = 2;
    localparam int M_RUN  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         mode_run;
    logic         step;
    logic         en0, en1;
    logic [W-1:0] cnt0, cnt1;
    logic [1:0]   st0, st1;

    cpu_step_controller #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .RUN_DIV(4), .CNT_W(W)
    ) u_div4 (
        .clk(clk), .rst(rst), .mode_run(mode_run), .step(step),
        .cpu_en(en0), .step_count(cnt0), .state_dbg(st0)
    );

    cpu_step_controller #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .RUN_DIV(1), .CNT_W(W)
    ) u_div1 (
        .clk(clk), .rst(rst), .mode_run(mode_run), .step(step),
        .cpu_en(en1), .step_count(cnt1), .state_dbg(st1)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // Inputs change and outputs are read 1 time unit after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    // Raw inputs appear to the debouncer S clocks late; a level is accepted once
    // the last D synchronized samples all disagree with the current level.
    logic [S-1:0] h_step, h_run;
    logic [D-1:0] w_step, w_run;
    bit           l_step, l_run, l_step_prev, m_rise;
    int           md    [2];
    bit           men   [2];
    logic [W-1:0] mcnt  [2];
    int           age   [2];
    int           rdiv  [2] = '{4, 1};

    initial begin
        h_step = '0; h_run = '0; w_step = '0; w_run = '0;
        l_step = 0; l_run = 0; l_step_prev = 0; m_rise = 0;
        for (int k = 0; k < 2; k++) begin
            md[k] = M_IDLE; men[k] = 0; mcnt[k] = '0; age[k] = 0;
        end
    end

    always @(posedge clk) begin : model
        bit s_sync, r_sync;
        if (rst) begin
            h_step = '0; h_run = '0; w_step = '0; w_run = '0;
            l_step = 0; l_run = 0; l_step_prev = 0; m_rise = 0;
            for (int k = 0; k < 2; k++) begin
                md[k] = M_IDLE; men[k] = 0; mcnt[k] = '0; age[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                mcnt[k] = mcnt[k] + (men[k] ? 16'd1 : 16'd0);
                men[k]  = 0;
                case (md[k])
                    M_IDLE: begin
                        if (l_run) begin
                            md[k] = M_RUN; age[k] = 0;
                        end else if (m_rise) begin
                            md[k] = M_STEP; men[k] = 1;
                        end
                    end
                    M_STEP: md[k] = M_WAIT;
                    M_WAIT: if (!l_step) md[k] = M_IDLE;
                    default: begin
                        if (!l_run) begin
                            md[k] = M_IDLE;
                        end else begin
                            age[k] = age[k] + 1;
                            men[k] = ((age[k] % rdiv[k]) == 0);
                        end
                    end
                endcase
            end
            m_rise      = l_step & ~l_step_prev;
            l_step_prev = l_step;
            s_sync = h_step[S-1];
            r_sync = h_run[S-1];
            h_step = {h_step[S-2:0], step};
            h_run  = {h_run[S-2:0], mode_run};
            w_step = {w_step[D-2:0], s_sync};
            w_run  = {w_run[D-2:0], r_sync};
            if (w_step == {D{~l_step}}) l_step = ~l_step;
            if (w_run == {D{~l_run}}) l_run = ~l_run;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("div4_cpu_en", en0, men[0]);
        chk("div4_count", cnt0, mcnt[0]);
        chk("div4_state", st0, md[0]);
        chk("div1_cpu_en", en1, men[1]);
        chk("div1_count", cnt1, mcnt[1]);
        chk("div1_state", st1, md[1]);
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int           pulses;
        int           t_hit;
        int           took;
        logic [W-1:0] c_before;

        rst = 1'b1; step = 1'b1; mode_run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_cpu_en", en0, 0);
            chk("rst_count", cnt0, 0);
            chk("rst_state", st0, 0);
        end
        rst = 1'b0; step = 1'b0; mode_run = 1'b0;
        repeat (10) tick();

        // Clean step press held 40 clocks.
        step = 1'b1; pulses = 0; t_hit = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (en0) begin pulses++; t_hit = i; end
            if (i == 30) chk("step_wait_rel", st0, 2);
        end
        chk("step_pulses", pulses, 1);
        chk("step_latency", t_hit, 20);
        chk("step_count", cnt0, 1);
        step = 1'b0;
        repeat (25) tick();
        chk("step_back_idle", st0, 0);

        // Bouncy press: toggle every 3 clocks, then settle high.
        pulses = 0;
        for (int j = 0; j < 30; j++) begin
            step = ((j / 3) % 2 == 0);
            tick();
            if (en0) pulses++;
        end
        step = 1'b1;
        for (int j = 0; j < 60; j++) begin
            tick();
            if (en0) pulses++;
        end
        chk("bounce_pulses", pulses, 1);
        step = 1'b0;
        repeat (30) tick();
        chk("bounce_count", cnt0, 2);

        // Run mode with random step presses that must be ignored.
        mode_run = 1'b1; took = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (st0 == 2'd3) begin took = i; break; end
        end
        chk("run_enter_latency", took, 19);
        c_before = cnt0; pulses = 0;
        for (int i = 1; i <= 100; i++) begin
            if ($urandom_range(0, 5) == 0) step = ~step;
            tick();
            if (en0) pulses++;
        end
        tick();
        chk("run_pulses", pulses, 25);
        chk("run_count_delta", 16'(cnt0 - c_before), 25);
        step = 1'b0;

        // RUN_DIV=1 instance keeps cpu_en high; let its counter wrap.
        took = -1;
        for (int i = 0; i < 70000; i++) begin
            tick();
            if (cnt1 == 16'hFFFF) begin took = i; break; end
        end
        chk("wrap_reached", (took >= 0), 1);
        tick();
        chk("wrap_to_zero", cnt1, 0);

        mode_run = 1'b0; took = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (st1 == 2'd0) begin took = i; break; end
        end
        chk("exit_latency", took, 19);
        chk("exit_cycle_en", en1, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("exit_quiet", en1, 0);
        end

        // Reset on a run pulse, then re-acceptance of the held run switch.
        mode_run = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (st0 == 2'd3) break;
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (en0) break;
        end
        chk("mid_run_pulse_seen", en0, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_cpu_en", en0, 0);
        chk("mid_rst_count", cnt0, 0);
        chk("mid_rst_state", st0, 0);
        rst = 1'b0; took = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (st0 == 2'd3) begin took = i; break; end
        end
        chk("rerun_latency", took, 19);

        // Random soak with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 19) == 0) step = ~step;
            if ($urandom_range(0, 149) == 0) mode_run = ~mode_run;
            tick();
        end
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
